// File: rtl/cond_logic.sv
// Conditional-execution unit for the multicycle ARM datapath: holds NZCV,
// evaluates the condition field and qualifies PC/register/memory write enables.
module cond_logic #(
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        Cond,
  input  logic [FLAG_W-1:0] ALUFlags,
  input  logic [1:0]        FlagW,
  input  logic              PCS,
  input  logic              NextPC,
  input  logic              RegW,
  input  logic              MemW,
  output logic              PCWrite,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic [FLAG_W-1:0] Flags
);

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              cond_ex_q, cond_ex_d;
  logic [1:0]        flag_write;
  logic              flag_n, flag_z, flag_c, flag_v;

  // Condition is evaluated on the registered flags only, so a flag-setting
  // instruction never sees its own ALU result in the same cycle.
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_ex_d = 1'b0;
    unique case (cond_e'(Cond))
      COND_EQ: cond_ex_d = flag_z;
      COND_NE: cond_ex_d = ~flag_z;
      COND_CS: cond_ex_d = flag_c;
      COND_CC: cond_ex_d = ~flag_c;
      COND_MI: cond_ex_d = flag_n;
      COND_PL: cond_ex_d = ~flag_n;
      COND_VS: cond_ex_d = flag_v;
      COND_VC: cond_ex_d = ~flag_v;
      COND_HI: cond_ex_d = flag_c & ~flag_z;
      COND_LS: cond_ex_d = ~(flag_c & ~flag_z);
      COND_GE: cond_ex_d = (flag_n == flag_v);
      COND_LT: cond_ex_d = (flag_n != flag_v);
      COND_GT: cond_ex_d = ~flag_z & (flag_n == flag_v);
      COND_LE: cond_ex_d = ~(~flag_z & (flag_n == flag_v));
      COND_AL: cond_ex_d = 1'b1;
      COND_NV: cond_ex_d = 1'b0;
      default: cond_ex_d = 1'b0;
    endcase
  end

  assign flag_write = FlagW & {2{cond_ex_d}};

  always_comb begin
    flags_d = flags_q;
    if (flag_write[1]) flags_d[3:2] = ALUFlags[3:2];
    if (flag_write[0]) flags_d[1:0] = ALUFlags[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q   <= '0;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  // FETCH increments are never gated by the condition.
  assign PCWrite  = NextPC | (PCS & cond_ex_q);
  assign RegWrite = RegW & cond_ex_q;
  assign MemWrite = MemW & cond_ex_q;
  assign Flags    = flags_q;

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed scenarios, exhaustive
// condition sweep and randomized traffic against a behavioural model.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, ALUFlags, Flags;
  logic [1:0] FlagW;
  logic       PCS, NextPC, RegW, MemW;
  logic       PCWrite, RegWrite, MemWrite;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] flags_m;
  bit         cex_m;

  cond_logic dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .Flags(Flags)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Conditions come in complementary pairs: even code is the base test,
  // odd code its inverse. E is always, F is never.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    {n, z, cy, v} = f;
    if (c == 4'hE) return 1'b1;
    if (c == 4'hF) return 1'b0;
    case (c >> 1)
      0: base = z;
      1: base = cy;
      2: base = n;
      3: base = v;
      4: base = cy && !z;
      5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic tick();
    bit         ok;
    logic [3:0] nf;
    ok = cond_ok(Cond, flags_m);
    nf = flags_m;
    if (ok && FlagW[1]) nf[3:2] = ALUFlags[3:2];
    if (ok && FlagW[0]) nf[1:0] = ALUFlags[1:0];
    @(posedge clk);
    if (reset) begin
      flags_m = 4'h0;
      cex_m   = 1'b0;
    end else begin
      flags_m = nf;
      cex_m   = ok;
    end
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; Cond = 4'hE; ALUFlags = 0; FlagW = 0;
    PCS = 0; NextPC = 0; RegW = 0; MemW = 0;
  endtask

  task automatic set_flags(input logic [3:0] f);
    Cond = 4'hE; FlagW = 2'b11; ALUFlags = f;
    tick();
    FlagW = 2'b00;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; ALUFlags = 4'hF; FlagW = 2'b11; Cond = 4'hE; RegW = 1; MemW = 1;
    tick();
    reset = 0; FlagW = 2'b00; PCS = 1; NextPC = 0;
    #1;
    n_checks++; if (Flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags got %h exp 0", Flags); end
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite got %b exp 0", RegWrite); end
    n_checks++; if (MemWrite !== 1'b0) begin n_fail++; $display("FAIL reset_memwrite got %b exp 0", MemWrite); end
    n_checks++; if (PCWrite !== 1'b0) begin n_fail++; $display("FAIL reset_pcwrite_nonext got %b exp 0", PCWrite); end
    NextPC = 1; #1;
    n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL reset_pcwrite_next got %b exp 1", PCWrite); end
    idle_inputs();
  endtask

  task automatic test_flag_update();
    idle_inputs();
    reset = 1; tick(); reset = 0;
    Cond = 4'hE; FlagW = 2'b10; ALUFlags = 4'b1111;
    tick();
    n_checks++; if (Flags !== 4'b1100) begin n_fail++; $display("FAIL flag_nz_only got %b exp 1100", Flags); end
    FlagW = 2'b01; ALUFlags = 4'b0011;
    tick();
    n_checks++; if (Flags !== 4'b1111) begin n_fail++; $display("FAIL flag_cv_only got %b exp 1111", Flags); end
    idle_inputs();
  endtask

  task automatic test_cond_gating();
    idle_inputs();
    set_flags(4'b0100);
    Cond = 4'h1; tick();
    RegW = 1; MemW = 1; #1;
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL gate_ne_regwrite got %b exp 0", RegWrite); end
    n_checks++; if (MemWrite !== 1'b0) begin n_fail++; $display("FAIL gate_ne_memwrite got %b exp 0", MemWrite); end
    RegW = 0; MemW = 0;
    Cond = 4'h0; tick();
    RegW = 1; MemW = 1; #1;
    n_checks++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL gate_eq_regwrite got %b exp 1", RegWrite); end
    n_checks++; if (MemWrite !== 1'b1) begin n_fail++; $display("FAIL gate_eq_memwrite got %b exp 1", MemWrite); end
    idle_inputs();
  endtask

  task automatic test_branch();
    idle_inputs();
    set_flags(4'b1000);
    Cond = 4'hB; tick();
    PCS = 1; NextPC = 0; #1;
    n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL branch_lt got %b exp 1", PCWrite); end
    NextPC = 1; #1;
    n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL branch_lt_nextpc got %b exp 1", PCWrite); end
    PCS = 0; NextPC = 0;
    Cond = 4'hA; tick();
    PCS = 1; #1;
    n_checks++; if (PCWrite !== 1'b0) begin n_fail++; $display("FAIL branch_ge got %b exp 0", PCWrite); end
    NextPC = 1; #1;
    n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL branch_ge_nextpc got %b exp 1", PCWrite); end
    idle_inputs();
  endtask

  task automatic test_suppressed();
    idle_inputs();
    set_flags(4'b0010);
    Cond = 4'h0; FlagW = 2'b11; ALUFlags = 4'b0100;
    tick();
    n_checks++; if (Flags !== 4'b0010) begin n_fail++; $display("FAIL suppress_eq got %b exp 0010", Flags); end
    Cond = 4'hF; ALUFlags = 4'b1101;
    tick();
    n_checks++; if (Flags !== 4'b0010) begin n_fail++; $display("FAIL suppress_nv got %b exp 0010", Flags); end
    idle_inputs();
  endtask

  // Same-cycle flag write and register write: both see pre-update state.
  task automatic test_back_to_back();
    idle_inputs();
    set_flags(4'b0000);
    Cond = 4'h0; tick();
    FlagW = 2'b11; ALUFlags = 4'b0100; RegW = 1; #1;
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL b2b_regwrite got %b exp 0", RegWrite); end
    tick();
    n_checks++; if (Flags !== 4'b0000) begin n_fail++; $display("FAIL b2b_flags got %b exp 0000", Flags); end
    Cond = 4'hE; tick();
    n_checks++; if (Flags !== 4'b0100) begin n_fail++; $display("FAIL b2b_flags_al got %b exp 0100", Flags); end
    idle_inputs();
  endtask

  task automatic test_sweep();
    bit exp;
    idle_inputs();
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        set_flags(4'(f));
        RegW = 0; Cond = 4'(c);
        tick();
        RegW = 1; #1;
        exp = cond_ok(4'(c), 4'(f));
        n_checks++;
        if (RegWrite !== exp) begin
          n_fail++;
          $display("FAIL sweep cond=%h flags=%b got %b exp %b", c, f, RegWrite, exp);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    bit e_rw, e_mw, e_pc;
    idle_inputs();
    reset = 1; tick(); reset = 0;
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 39) == 0);
      Cond     = 4'($urandom_range(0, 15));
      ALUFlags = 4'($urandom_range(0, 15));
      FlagW    = 2'($urandom_range(0, 3));
      PCS      = 1'($urandom_range(0, 1));
      NextPC   = 1'($urandom_range(0, 1));
      RegW     = 1'($urandom_range(0, 1));
      MemW     = 1'($urandom_range(0, 1));
      #1;
      e_rw = RegW && cex_m;
      e_mw = MemW && cex_m;
      e_pc = NextPC || (PCS && cex_m);
      n_checks++;
      if (Flags !== flags_m || RegWrite !== e_rw || MemWrite !== e_mw || PCWrite !== e_pc) begin
        n_fail++;
        $display("FAIL random i=%0d got flags=%b rw=%b mw=%b pc=%b exp flags=%b rw=%b mw=%b pc=%b",
                 i, Flags, RegWrite, MemWrite, PCWrite, flags_m, e_rw, e_mw, e_pc);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    flags_m = 4'h0;
    cex_m   = 1'b0;
    reset   = 1;
    tick();
    tick();
    test_reset();
    test_flag_update();
    test_cond_gating();
    test_branch();
    test_suppressed();
    test_back_to_back();
    test_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Conditional-execution unit for the multicycle ARM datapath. It sits directly downstream of the main control FSM, which drives NextPC, Branch, RegW, MemW and FlagW each cycle.
- Holds the NZCV status flags and evaluates the instruction condition field against them.
- Registers the condition result so later states of the same instruction are gated by it.
- Produces the architecturally qualified write enables PCWrite, RegWrite and MemWrite for the datapath.

Parameters:
- FLAG_W, 4, status flag width; fixed at 4 (N,Z,C,V), present for documentation only.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Cond  input  4  instruction bits [31:28], stable from IR for the whole instruction
- ALUFlags  input  4  {N,Z,C,V} from the ALU, current cycle
- FlagW  input  2  from the ALU decoder; [1] updates N,Z; [0] updates C,V
- PCS  input  1  PC-source request (Branch from the FSM, or a register write with Rd==15)
- NextPC  input  1  unconditional PC write from the FSM (FETCH)
- RegW  input  1  register-write request from the FSM
- MemW  input  1  memory-write request from the FSM
- PCWrite  output  1  qualified PC enable
- RegWrite  output  1  qualified register-file write enable
- MemWrite  output  1  qualified memory write enable
- Flags  output  4  current registered {N,Z,C,V}, for debug and test

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - Flags <= 4'b0000.
  - CondExReg <= 0.
  - In the cycle after reset, RegWrite=MemWrite=0 and PCWrite=NextPC.
  - Reset asserted mid-instruction aborts it: no flag update occurs on that edge, even if FlagW is nonzero.
- Condition check, combinational on Cond and the registered Flags {N,Z,C,V}, producing CondEx:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !(C&!Z)
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: !(!Z&(N==V))
  - E AL: 1
  - F: 0 (treated as never; no writes)
- Flag registers:
  - FlagWrite = FlagW & {2{CondEx}}.
  - Flags[3:2] <= ALUFlags[3:2] when FlagWrite[1].
  - Flags[1:0] <= ALUFlags[1:0] when FlagWrite[0].
  - Otherwise each pair holds its value.
  - The update is visible on Flags the cycle after the write edge.
  - CondEx within the write cycle uses the old flags; no combinational path exists from ALUFlags to CondEx.
- CondExReg:
  - Loads CondEx on every clk edge (no enable); one cycle latency.
  - The FSM guarantees Cond is valid in DECODE, so CondExReg is valid from EXECUTE/MEMADR onward for that instruction.
- Outputs (combinational from registered state and inputs):
  - RegWrite = RegW & CondExReg.
  - MemWrite = MemW & CondExReg.
  - PCWrite = NextPC | (PCS & CondExReg).
  - NextPC is never gated; a FETCH PC increment always occurs.
- Simultaneous events:
  - FlagW and RegW in the same cycle: RegWrite uses CondExReg (pre-update); the flag write uses CondEx (pre-update flags).
  - NextPC and PCS together: PCWrite=1.
- No internal FSM. The only state is the 4 flag bits and 1 CondExReg bit.

Test Plan:
- Reset:
  - Stimulus: reset=1 for 1 cycle with ALUFlags=4'hF, FlagW=2'b11, Cond=E, RegW=1.
  - Response: Flags=0 after the edge; RegWrite=0 in the following cycle; MemWrite=0.
- Flag update with partial enable:
  - Stimulus: Flags=0, Cond=E, FlagW=2'b10, ALUFlags=4'b1111 for one edge.
  - Response: Flags=4'b1100.
  - Then FlagW=2'b01, ALUFlags=4'b0011 for one edge: Flags=4'b1111.
- Condition gating:
  - Stimulus: Flags={N=0,Z=1,C=0,V=0}, Cond=1 (NE), hold 1 edge, then RegW=1, MemW=1.
  - Response: RegWrite=0, MemWrite=0.
  - Repeat with Cond=0 (EQ): RegWrite=1, MemWrite=1.
- Branch:
  - Stimulus: Flags N=1,V=0, Cond=B (LT), 1 edge, then PCS=1, NextPC=0.
  - Response: PCWrite=1.
  - With Cond=A (GE): PCWrite=0.
  - With NextPC=1 under either condition: PCWrite=1.
- Suppressed flag write:
  - Stimulus: Flags Z=0, Cond=0 (EQ), FlagW=2'b11, ALUFlags=4'b0100.
  - Response: Flags unchanged (Z stays 0).
  - Cond=F with FlagW=2'b11: Flags unchanged.
- Exhaustive sweep: all 16 Cond × 16 Flags values checked against the condition table via RegW=1 one cycle later.
